// File: rtl/ahb_slave_ctrl_pkg.sv
// Shared types and constants for the AHB-Lite slave control stage in front of AMBA_inout.
package ahb_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_KEY,
        WR_DATA,
        RD_WAIT,
        RD_ISSUE,
        RD_LAT,
        RD_DONE,
        ERR1,
        ERR2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HSIZE_128     = 3'b100;

    localparam logic [7:0] KEY_OFS_DEF = 8'h00;
    localparam logic [7:0] DWR_OFS_DEF = 8'h10;
    localparam logic [7:0] DRD_OFS_DEF = 8'h20;

    typedef struct packed {
        logic writek;
        logic writed;
        logic readd;
        logic hready;
        logic herr;
    } ctrl_out_t;

    // Output vector held while the FSM sits in state s.
    function automatic ctrl_out_t state_outputs(input state_t s);
        ctrl_out_t o;
        o        = '0;
        o.hready = 1'b1;
        case (s)
            WR_KEY:   o.writek = 1'b1;
            WR_DATA:  o.writed = 1'b1;
            RD_WAIT:  o.hready = 1'b0;
            RD_ISSUE: begin
                o.readd  = 1'b1;
                o.hready = 1'b0;
            end
            RD_LAT:   o.hready = 1'b0;
            ERR1: begin
                o.herr   = 1'b1;
                o.hready = 1'b0;
            end
            ERR2:     o.herr = 1'b1;
            default:  o.hready = 1'b1;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/ahb_slave_ctrl_if.sv
// AHB address-phase inputs, AES busy flag and AMBA_inout command/response controls.
interface ahb_slave_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic                  HWRITE;
    logic [1:0]            HTRANS;
    logic [2:0]            HSIZE;
    logic                  HREADY;
    logic                  aes_busy;
    logic                  writek_enable;
    logic                  writed_enable;
    logic                  readd_enable;
    logic                  hready_enable;
    logic                  hresp_error;

    modport master (
        output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HREADY, aes_busy,
        input  writek_enable, writed_enable, readd_enable, hready_enable, hresp_error
    );

    modport slave (
        input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HREADY, aes_busy,
        output writek_enable, writed_enable, readd_enable, hready_enable, hresp_error
    );
endinterface

// File: rtl/ahb_slave_ctrl_decode.sv
// Combinational AHB address-phase decoder: validity plus the state the phase maps to.
module ahb_addr_decode
    import ahb_ctrl_pkg::*;
#(
    parameter logic [7:0] KEY_OFS = KEY_OFS_DEF,
    parameter logic [7:0] DWR_OFS = DWR_OFS_DEF,
    parameter logic [7:0] DRD_OFS = DRD_OFS_DEF
) (
    input  logic       i_hsel,
    input  logic [7:0] i_hofs,
    input  logic       i_hwrite,
    input  logic [1:0] i_htrans,
    input  logic [2:0] i_hsize,
    input  logic       i_hready,
    output logic       o_valid,
    output state_t     o_state
);

    always_comb begin
        o_valid = i_hsel && i_hready &&
                  (i_htrans == HTRANS_NONSEQ || i_htrans == HTRANS_SEQ);
        o_state = ERR1;
        if (i_hsize == HSIZE_128) begin
            if (i_hwrite && i_hofs == KEY_OFS)
                o_state = WR_KEY;
            else if (i_hwrite && i_hofs == DWR_OFS)
                o_state = WR_DATA;
            else if (!i_hwrite && i_hofs == DRD_OFS)
                o_state = RD_WAIT;
        end
    end

endmodule

// File: rtl/ahb_slave_ctrl.sv
// AHB-Lite slave control FSM: issues AMBA_inout strobes, stalls reads while the AES core is busy.
module ahb_slave_ctrl
    import ahb_ctrl_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [7:0] KEY_OFS    = KEY_OFS_DEF,
    parameter logic [7:0] DWR_OFS    = DWR_OFS_DEF,
    parameter logic [7:0] DRD_OFS    = DRD_OFS_DEF,
    parameter int         READ_LAT   = 1
) (
    input logic              clk,
    input logic              rst,
    ahb_slave_ctrl_if.slave  bus
);

    localparam logic [1:0] LAT_LOAD = 2'(READ_LAT - 1);

    state_t     r_state;
    logic [1:0] r_lat_cnt;
    ctrl_out_t  r_out;

    logic       w_dec_valid;
    state_t     w_dec_state;
    state_t     w_next_state;
    logic       w_unused_haddr;

    assign w_unused_haddr = ^bus.HADDR[ADDR_WIDTH-1:8];

    ahb_addr_decode #(
        .KEY_OFS (KEY_OFS),
        .DWR_OFS (DWR_OFS),
        .DRD_OFS (DRD_OFS)
    ) u_decode (
        .i_hsel   (bus.HSEL),
        .i_hofs   (bus.HADDR[7:0]),
        .i_hwrite (bus.HWRITE),
        .i_htrans (bus.HTRANS),
        .i_hsize  (bus.HSIZE),
        .i_hready (bus.HREADY),
        .o_valid  (w_dec_valid),
        .o_state  (w_dec_state)
    );

    // Every state with HREADYOUT high accepts a pipelined address phase.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, WR_KEY, WR_DATA, RD_DONE, ERR2:
                w_next_state = w_dec_valid ? w_dec_state : IDLE;
            RD_WAIT:  w_next_state = bus.aes_busy ? RD_WAIT : RD_ISSUE;
            RD_ISSUE: w_next_state = RD_LAT;
            RD_LAT:   w_next_state = (r_lat_cnt == '0) ? RD_DONE : RD_LAT;
            ERR1:     w_next_state = ERR2;
            default:  w_next_state = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_lat_cnt <= '0;
            r_out     <= state_outputs(IDLE);
        end else begin
            r_state <= w_next_state;
            r_out   <= state_outputs(w_next_state);
            if (r_state == RD_ISSUE)
                r_lat_cnt <= LAT_LOAD;
            else if (r_state == RD_LAT && r_lat_cnt != '0)
                r_lat_cnt <= r_lat_cnt - 2'd1;
        end
    end

    assign bus.writek_enable = r_out.writek;
    assign bus.writed_enable = r_out.writed;
    assign bus.readd_enable  = r_out.readd;
    assign bus.hready_enable = r_out.hready;
    assign bus.hresp_error   = r_out.herr;

endmodule

// File: tb/tb_ahb_slave_ctrl.sv
// Scoreboard bench for ahb_slave_ctrl: expected {err,rdy,readd,writed,writek} per cycle.
module tb_ahb_slave_ctrl;

    typedef struct packed {
        logic       sel;
        logic       rdy;
        logic       wr;
        logic [1:0] tr;
        logic [2:0] sz;
        logic [7:0] ofs;
        logic       busy;
    } stim_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [4:0] obs;
    logic [4:0] exp_v;
    logic [4:0] sb[$];

    ahb_slave_ctrl_if #(.ADDR_WIDTH(32)) bus ();

    ahb_slave_ctrl #(
        .ADDR_WIDTH (32),
        .KEY_OFS    (8'h00),
        .DWR_OFS    (8'h10),
        .DRD_OFS    (8'h20),
        .READ_LAT   (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t ph(input logic sel, input logic rdy, input logic wr,
                                 input logic [1:0] tr, input logic [2:0] sz,
                                 input logic [7:0] ofs, input logic busy);
        stim_t s;
        s = '{sel: sel, rdy: rdy, wr: wr, tr: tr, sz: sz, ofs: ofs, busy: busy};
        return s;
    endfunction

    localparam logic [4:0] E_IDLE = 5'b01000;
    localparam logic [4:0] E_WK   = 5'b01001;
    localparam logic [4:0] E_WD   = 5'b01010;
    localparam logic [4:0] E_RWT  = 5'b00000;
    localparam logic [4:0] E_RIS  = 5'b00100;
    localparam logic [4:0] E_ER1  = 5'b10000;
    localparam logic [4:0] E_ER2  = 5'b11000;

    task automatic sample();
        obs = {bus.hresp_error, bus.hready_enable, bus.readd_enable,
               bus.writed_enable, bus.writek_enable};
    endtask

    task automatic apply_and_step(input stim_t s);
        logic [31:0] r;
        r          = $urandom();
        bus.HSEL   = s.sel;
        bus.HREADY = s.rdy;
        bus.HWRITE = s.wr;
        bus.HTRANS = s.tr;
        bus.HSIZE  = s.sz;
        bus.HADDR  = {r[31:8], s.ofs};
        bus.aes_busy = s.busy;
        @(posedge clk);
        #1;
        sample();
    endtask

    function automatic stim_t idle_ph(input logic busy);
        return ph(1'b0, 1'b1, 1'b0, 2'b00, 3'b100, 8'h00, busy);
    endfunction

    task automatic test_reset();
        stim_t st[6];
        sb.push_back(E_IDLE);
        sample();
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL reset_initial: got %b want %b", obs, exp_v);
        end
        rst = 1'b0;
        st[0] = ph(1, 1, 0, 2'b10, 3'b100, 8'h20, 0);
        st[1] = idle_ph(0);
        sb.push_back(E_RWT);
        sb.push_back(E_RIS);
        for (int i = 0; i < 2; i++) begin
            apply_and_step(st[i]);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL reset_preread[%0d]: got %b want %b", i, obs, exp_v);
            end
        end
        #2 rst = 1'b1;
        #1 sample();
        sb.push_back(E_IDLE);
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL reset_async: got %b want %b", obs, exp_v);
        end
        st[2] = ph(1, 1, 1, 2'b10, 3'b100, 8'h00, 0);
        st[3] = idle_ph(0);
        st[4] = ph(1, 1, 1, 2'b10, 3'b100, 8'h00, 0);
        st[5] = idle_ph(0);
        sb.push_back(E_IDLE);
        sb.push_back(E_IDLE);
        sb.push_back(E_WK);
        sb.push_back(E_IDLE);
        for (int i = 2; i < 6; i++) begin
            apply_and_step(st[i]);
            if (i == 2) rst = 1'b0;
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL reset_after[%0d]: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_key_write();
        stim_t st[2];
        st[0] = ph(1, 1, 1, 2'b10, 3'b100, 8'h00, 0);
        st[1] = idle_ph(0);
        sb.push_back(E_WK);
        sb.push_back(E_IDLE);
        for (int i = 0; i < 2; i++) begin
            apply_and_step(st[i]);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL key_write[%0d]: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[4];
        st[0] = ph(1, 1, 1, 2'b10, 3'b100, 8'h00, 0);
        st[1] = ph(1, 1, 1, 2'b11, 3'b100, 8'h10, 0);
        st[2] = ph(1, 1, 1, 2'b10, 3'b100, 8'h00, 0);
        st[3] = idle_ph(0);
        sb.push_back(E_WK);
        sb.push_back(E_WD);
        sb.push_back(E_WK);
        sb.push_back(E_IDLE);
        for (int i = 0; i < 4; i++) begin
            apply_and_step(st[i]);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_read();
        stim_t st[6];
        st[0] = ph(1, 1, 0, 2'b10, 3'b100, 8'h20, 0);
        st[1] = ph(1, 1, 0, 2'b00, 3'b100, 8'h20, 0);
        st[2] = ph(1, 1, 1, 2'b10, 3'b100, 8'h00, 0);
        st[3] = ph(1, 1, 1, 2'b10, 3'b100, 8'h00, 0);
        st[4] = ph(1, 1, 1, 2'b10, 3'b100, 8'h10, 0);
        st[5] = idle_ph(0);
        sb.push_back(E_RWT);
        sb.push_back(E_RIS);
        sb.push_back(E_RWT);
        sb.push_back(E_IDLE);
        sb.push_back(E_WD);
        sb.push_back(E_IDLE);
        for (int i = 0; i < 6; i++) begin
            apply_and_step(st[i]);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL read[%0d]: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_read_busy();
        stim_t st[9];
        st[0] = ph(1, 1, 0, 2'b10, 3'b100, 8'h20, 1);
        st[1] = idle_ph(1);
        st[2] = ph(1, 1, 0, 2'b01, 3'b100, 8'h20, 1);
        st[3] = ph(1, 1, 1, 2'b10, 3'b100, 8'h00, 1);
        st[4] = idle_ph(1);
        st[5] = idle_ph(0);
        st[6] = idle_ph(1);
        st[7] = idle_ph(1);
        st[8] = idle_ph(0);
        for (int i = 0; i < 5; i++) sb.push_back(E_RWT);
        sb.push_back(E_RIS);
        sb.push_back(E_RWT);
        sb.push_back(E_IDLE);
        sb.push_back(E_IDLE);
        for (int i = 0; i < 9; i++) begin
            apply_and_step(st[i]);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL read_busy[%0d]: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_errors();
        stim_t st[10];
        st[0] = ph(1, 1, 1, 2'b10, 3'b100, 8'h24, 0);
        st[1] = idle_ph(0);
        st[2] = idle_ph(0);
        st[3] = ph(1, 1, 0, 2'b10, 3'b010, 8'h20, 0);
        st[4] = idle_ph(0);
        st[5] = ph(1, 1, 1, 2'b11, 3'b100, 8'h00, 0);
        st[6] = ph(1, 1, 0, 2'b10, 3'b100, 8'h00, 0);
        st[7] = idle_ph(0);
        st[8] = ph(1, 1, 1, 2'b10, 3'b100, 8'h20, 0);
        st[9] = idle_ph(0);
        sb.push_back(E_ER1);
        sb.push_back(E_ER2);
        sb.push_back(E_IDLE);
        sb.push_back(E_ER1);
        sb.push_back(E_ER2);
        sb.push_back(E_WK);
        sb.push_back(E_ER1);
        sb.push_back(E_ER2);
        sb.push_back(E_ER1);
        sb.push_back(E_ER2);
        for (int i = 0; i < 10; i++) begin
            apply_and_step(st[i]);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL errors[%0d]: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_idle_busy_trans();
        stim_t st[5];
        st[0] = ph(1, 1, 1, 2'b00, 3'b100, 8'h00, 0);
        st[1] = ph(1, 1, 1, 2'b01, 3'b100, 8'h10, 0);
        st[2] = ph(1, 0, 1, 2'b10, 3'b100, 8'h00, 0);
        st[3] = ph(0, 1, 0, 2'b10, 3'b100, 8'h20, 0);
        st[4] = ph(1, 1, 0, 2'b01, 3'b100, 8'h24, 0);
        for (int i = 0; i < 5; i++) sb.push_back(E_IDLE);
        for (int i = 0; i < 5; i++) begin
            apply_and_step(st[i]);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL idle_busy_trans[%0d]: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b1;
        bus.HSEL     = 1'b0;
        bus.HADDR    = '0;
        bus.HWRITE   = 1'b0;
        bus.HTRANS   = 2'b00;
        bus.HSIZE    = 3'b100;
        bus.HREADY   = 1'b1;
        bus.aes_busy = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_key_write();
        test_back_to_back();
        test_read();
        test_read_busy();
        test_errors();
        test_idle_busy_trans();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
